// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard control, processor status and run/halt/timeout FSM for a
// five-stage Y86-64 pipeline, plus saturating performance counters.
module pipe_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             W_valid,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [2:0]       proc_stat,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  // Status encodings
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Instruction codes
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  // Counter slot indices inside the counter array
  localparam int C_CYCLE   = 0;
  localparam int C_RETIRED = 1;
  localparam int C_LU      = 2;
  localparam int C_MP      = 3;
  localparam int C_RET     = 4;
  localparam int N_CNT     = 5;

  // Last cycle_cnt value that is still allowed to run; the edge that leaves
  // this value is the one that trips the watchdog.
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam bit               WD_ON    = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HALTED  = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       stat_q;
  logic             halted_q;
  logic             timeout_q;

  logic             lu;
  logic             mp;
  logic             rt;
  logic             mx;
  logic             wx;
  logic             in_run;
  logic             wd_hit;

  logic [CNT_W-1:0] cnt_q [N_CNT];
  logic [N_CNT-1:0] cnt_inc;

  // True when a status code denotes an exception/halt condition.
  function automatic logic is_exc(input logic [2:0] s);
    return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
  endfunction

  // Hazard detection terms, purely from the current pipeline-register contents.
  always_comb begin
    lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
         (E_dstM != R_NONE) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mp = (E_icode == I_JXX) && !e_cnd;
    rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mx = is_exc(m_stat);
    wx = is_exc(W_stat);
  end

  assign in_run = (state_q == S_RUN);
  assign wd_hit = WD_ON && (cnt_q[C_CYCLE] == WD_LAST);

  // Pipeline controls: reset and the stopped states freeze/flush everything,
  // otherwise the hazard equations drive the stage registers.
  always_comb begin
    F_stall  = lu || rt;
    D_stall  = lu;
    D_bubble = mp || (!lu && rt);
    E_bubble = mp || lu;
    M_bubble = mx || wx;
    W_stall  = wx;
    set_cc   = (E_icode == I_OPQ) && !mx && !wx;
    if (rst) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b0;
      set_cc   = 1'b0;
    end else if (!in_run) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
    end
  end

  // Counter increment requests; W_stall is the RUN-state value (wx) here
  // because counters only move in RUN.
  always_comb begin
    cnt_inc          = '0;
    cnt_inc[C_CYCLE]   = 1'b1;
    cnt_inc[C_RETIRED] = W_valid && (W_stat == STAT_AOK) && !wx;
    cnt_inc[C_LU]      = lu;
    cnt_inc[C_MP]      = mp;
    cnt_inc[C_RET]     = rt && !lu;
  end

  // Run/halt/timeout FSM with registered status flags; a halt seen on the
  // same edge as the watchdog expiry takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      stat_q    <= STAT_AOK;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (wx) begin
            state_q  <= S_HALTED;
            stat_q   <= W_stat;
            halted_q <= 1'b1;
          end else if (wd_hit) begin
            state_q   <= S_TIMEOUT;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        S_HALTED, S_TIMEOUT: begin
          state_q <= state_q;
        end
        default: begin
          state_q   <= S_RUN;
          halted_q  <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  // One saturating counter per event; counting stops outside RUN.
  for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[gi] <= '0;
      end else if (in_run && cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
        cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end
    end
  end

  assign proc_stat    = stat_q;
  assign halted       = halted_q;
  assign timeout      = timeout_q;
  assign cycle_cnt    = cnt_q[C_CYCLE];
  assign retired_cnt  = cnt_q[C_RETIRED];
  assign lu_stall_cnt = cnt_q[C_LU];
  assign mispred_cnt  = cnt_q[C_MP];
  assign ret_cnt      = cnt_q[C_RET];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: a vector table for the combinational
// controls and counter increments, plus sequences for halt, reset, watchdog
// and counter saturation.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
  logic       e_cnd;
  logic [2:0] m_stat, W_stat;
  logic       W_valid;

  always #5 clk = ~clk;

  // Main instance: watchdog disabled
  logic        m_fs, m_ds, m_db, m_eb, m_mb, m_ws, m_cc, m_halt, m_to;
  logic [2:0]  m_ps;
  logic [31:0] m_cyc, m_ret, m_lu, m_mp, m_rt;
  pipe_ctrl #(.CNT_W(32), .MAX_CYCLES(0)) u_main (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat), .W_valid(W_valid),
    .F_stall(m_fs), .D_stall(m_ds), .D_bubble(m_db), .E_bubble(m_eb),
    .M_bubble(m_mb), .W_stall(m_ws), .set_cc(m_cc), .proc_stat(m_ps),
    .halted(m_halt), .timeout(m_to), .cycle_cnt(m_cyc), .retired_cnt(m_ret),
    .lu_stall_cnt(m_lu), .mispred_cnt(m_mp), .ret_cnt(m_rt));

  // Watchdog instance: limit of 8 cycles
  logic        w_fs, w_ds, w_db, w_eb, w_mb, w_ws, w_cc, w_halt, w_to;
  logic [2:0]  w_ps;
  logic [31:0] w_cyc, w_ret, w_lu, w_mp, w_rt;
  pipe_ctrl #(.CNT_W(32), .MAX_CYCLES(8)) u_wd (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat), .W_valid(W_valid),
    .F_stall(w_fs), .D_stall(w_ds), .D_bubble(w_db), .E_bubble(w_eb),
    .M_bubble(w_mb), .W_stall(w_ws), .set_cc(w_cc), .proc_stat(w_ps),
    .halted(w_halt), .timeout(w_to), .cycle_cnt(w_cyc), .retired_cnt(w_ret),
    .lu_stall_cnt(w_lu), .mispred_cnt(w_mp), .ret_cnt(w_rt));

  // Saturation instance: 3-bit counters
  logic        s_fs, s_ds, s_db, s_eb, s_mb, s_ws, s_cc, s_halt, s_to;
  logic [2:0]  s_ps;
  logic [2:0]  s_cyc, s_ret, s_lu, s_mp, s_rt;
  pipe_ctrl #(.CNT_W(3), .MAX_CYCLES(0)) u_sat (
    .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat), .W_valid(W_valid),
    .F_stall(s_fs), .D_stall(s_ds), .D_bubble(s_db), .E_bubble(s_eb),
    .M_bubble(s_mb), .W_stall(s_ws), .set_cc(s_cc), .proc_stat(s_ps),
    .halted(s_halt), .timeout(s_to), .cycle_cnt(s_cyc), .retired_cnt(s_ret),
    .lu_stall_cnt(s_lu), .mispred_cnt(s_mp), .ret_cnt(s_rt));

  logic [6:0] m_ctl, w_ctl;
  assign m_ctl = {m_fs, m_ds, m_db, m_eb, m_mb, m_ws, m_cc};
  assign w_ctl = {w_fs, w_ds, w_db, w_eb, w_mb, w_ws, w_cc};

  // ctl = {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
  // inc = {retired,lu_stall,mispred,ret} increments expected on the edge
  typedef struct {
    logic [3:0] d_ic, e_ic, m_ic, sa, sb, dm;
    logic       cnd;
    logic [2:0] ms, ws;
    logic       wv;
    logic [6:0] ctl;
    logic [3:0] inc;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] d, e, m, sa, sb, dm,
                              input logic cnd, input logic [2:0] ms, ws,
                              input logic wv, input logic [6:0] ctl,
                              input logic [3:0] inc);
    vec_t v;
    v.d_ic = d; v.e_ic = e; v.m_ic = m; v.sa = sa; v.sb = sb; v.dm = dm;
    v.cnd = cnd; v.ms = ms; v.ws = ws; v.wv = wv; v.ctl = ctl; v.inc = inc;
    return v;
  endfunction

  int checks = 0;
  int errors = 0;

  // Expected state of the main instance
  bit          exp_run;
  logic [2:0]  exp_ps;
  logic [31:0] exp_cyc, exp_ret, exp_lu, exp_mp, exp_rt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    D_icode = v.d_ic; E_icode = v.e_ic; M_icode = v.m_ic;
    d_srcA = v.sa; d_srcB = v.sb; E_dstM = v.dm;
    e_cnd = v.cnd; m_stat = v.ms; W_stat = v.ws; W_valid = v.wv;
  endtask

  // One clock of the main instance: controls before the edge, registered
  // state and counters after it.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #1;
    chk({nm, ".ctl"}, 64'(m_ctl), 64'(v.ctl));
    @(posedge clk);
    #1;
    if (exp_run) begin
      exp_cyc++;
      exp_ret += 32'(v.inc[3]);
      exp_lu  += 32'(v.inc[2]);
      exp_mp  += 32'(v.inc[1]);
      exp_rt  += 32'(v.inc[0]);
      if (v.ws inside {3'd2, 3'd3, 3'd4}) begin
        exp_run = 1'b0;
        exp_ps  = v.ws;
      end
    end
    $display("step %-10s ctl=%b halted=%0d stat=%0d cyc=%0d", nm, m_ctl, m_halt, m_ps, m_cyc);
    chk({nm, ".stat"},   64'(m_ps),   64'(exp_ps));
    chk({nm, ".halted"}, 64'(m_halt), 64'(!exp_run));
    chk({nm, ".timeout"},64'(m_to),   64'(0));
    chk({nm, ".cyc"},    64'(m_cyc),  64'(exp_cyc));
    chk({nm, ".retired"},64'(m_ret),  64'(exp_ret));
    chk({nm, ".lu"},     64'(m_lu),   64'(exp_lu));
    chk({nm, ".mp"},     64'(m_mp),   64'(exp_mp));
    chk({nm, ".ret"},    64'(m_rt),   64'(exp_rt));
  endtask

  vec_t nop;

  // Reset for one edge, checking the reset-time controls and reset values.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(nop);
    #1;
    chk("rst.ctl", 64'(m_ctl), 64'(7'b0011100));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_run = 1'b1; exp_ps = 3'd1;
    exp_cyc = 0; exp_ret = 0; exp_lu = 0; exp_mp = 0; exp_rt = 0;
    $display("reset stat=%0d halted=%0d cyc=%0d", m_ps, m_halt, m_cyc);
    chk("rst.stat",   64'(m_ps),   64'(1));
    chk("rst.halted", 64'(m_halt), 64'(0));
    chk("rst.timeout",64'(m_to),   64'(0));
    chk("rst.cyc",    64'(m_cyc),  64'(0));
    chk("rst.retired",64'(m_ret),  64'(0));
    chk("rst.ret",    64'(m_rt),   64'(0));
    chk("rst.wd_cyc", 64'(w_cyc),  64'(0));
  endtask

  vec_t tbl [15];

  initial begin
    vec_t   v;
    logic [31:0] base;

    nop = mk(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b0, 7'b0000000, 4'b0000);
    drive(nop);

    //            D     E     M     srcA  srcB  dstM  cnd   m_stat W_stat Wv  ctl          inc
    tbl[0]  = mk(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b0, 7'b0000000, 4'b0000);
    tbl[1]  = mk(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b0, 3'd1, 3'd1, 1'b0, 7'b1101000, 4'b0100);
    tbl[2]  = mk(4'h1, 4'h5, 4'h1, 4'h1, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b0, 7'b0000000, 4'b0000);
    tbl[3]  = mk(4'h1, 4'hB, 4'h1, 4'h1, 4'h4, 4'h4, 1'b0, 3'd1, 3'd1, 1'b0, 7'b1101000, 4'b0100);
    tbl[4]  = mk(4'h1, 4'h5, 4'h1, 4'h2, 4'h4, 4'h3, 1'b0, 3'd1, 3'd1, 1'b0, 7'b0000000, 4'b0000);
    tbl[5]  = mk(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b0, 7'b0011000, 4'b0010);
    tbl[6]  = mk(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1, 1'b0, 7'b0000000, 4'b0000);
    tbl[7]  = mk(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b0, 7'b1010000, 4'b0001);
    tbl[8]  = mk(4'h9, 4'h5, 4'h1, 4'h2, 4'hF, 4'h2, 1'b0, 3'd1, 3'd1, 1'b0, 7'b1101000, 4'b0100);
    tbl[9]  = mk(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b0, 7'b0000001, 4'b0000);
    tbl[10] = mk(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd3, 3'd1, 1'b0, 7'b0000100, 4'b0000);
    tbl[11] = mk(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd0, 3'd1, 1'b0, 7'b0000001, 4'b0000);
    tbl[12] = mk(4'h1, 4'h7, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b0, 7'b1011000, 4'b0011);
    tbl[13] = mk(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b1, 7'b0000000, 4'b1000);
    tbl[14] = mk(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 1'b0, 7'b1010000, 4'b0001);

    do_reset();

    // Table-driven control/counter vectors
    for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Three consecutive ret bubble cycles
    base = m_rt;
    for (int i = 0; i < 3; i++) step(tbl[7], "ret3");
    chk("ret3.delta", 64'(m_rt - base), 64'(3));

    // Halt: W_stat=HLT with an OPQ in E; set_cc must be suppressed
    v = mk(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd2, 1'b1, 7'b0000110, 4'b0000);
    step(v, "halt");
    chk("halt.stat2", 64'(m_ps), 64'(2));
    // Held in HALTED with a load/use pattern present: counters frozen
    v = mk(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b0, 3'd1, 3'd1, 1'b1, 7'b1101110, 4'b0000);
    step(v, "halted1");
    step(v, "halted2");
    do_reset();

    // Watchdog expiry after 8 RUN edges
    for (int i = 0; i < 7; i++) step(nop, "wd_run");
    chk("wd.to7",  64'(w_to),  64'(0));
    chk("wd.cyc7", 64'(w_cyc), 64'(7));
    step(nop, "wd_run");
    chk("wd.to8",   64'(w_to),   64'(1));
    chk("wd.halt8", 64'(w_halt), 64'(1));
    chk("wd.cyc8",  64'(w_cyc),  64'(8));
    chk("wd.stat8", 64'(w_ps),   64'(1));
    chk("wd.ctl",   64'(w_ctl),  64'(7'b1101110));
    step(nop, "wd_after");
    chk("wd.frozen", 64'(w_cyc), 64'(8));
    chk("wd.tohold", 64'(w_to),  64'(1));

    // Halt and watchdog expiry on the same edge: halt wins
    do_reset();
    for (int i = 0; i < 7; i++) step(nop, "wdx_run");
    v = mk(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd3, 1'b1, 7'b0000110, 4'b0000);
    step(v, "wdx_adr");
    chk("wdx.halt", 64'(w_halt), 64'(1));
    chk("wdx.to",   64'(w_to),   64'(0));
    chk("wdx.stat", 64'(w_ps),   64'(3));

    // Saturation of 3-bit counters
    do_reset();
    for (int i = 0; i < 10; i++) step(tbl[13], "sat");
    chk("sat.retired", 64'(s_ret), 64'(7));
    chk("sat.cyc",     64'(s_cyc), 64'(7));
    chk("sat.halt",    64'(s_halt),64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control and status unit for the five-stage Y86-64 pipeline. It generates the per-stage stall, bubble and condition-code-enable controls for load/use hazards, mispredicted jumps, `ret` and exceptions. It registers the processor status and runs a halt/timeout state machine. It keeps saturating performance counters. It sits beside the F/D/E/M/W pipeline registers in the processor top and replaces ad-hoc stat decoding and fixed-delay simulation stops.

## Interface
Parameters:
- `CNT_W`, default 32: width of every performance counter.
- `MAX_CYCLES`, default 1000: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `D_icode`, `E_icode`, `M_icode` in 4 each: icodes held in the D, E and M pipeline registers.
- `d_srcA`, `d_srcB` in 4 each: decode-stage source register IDs.
- `E_dstM` in 4: memory destination register of the instruction in E.
- `e_cnd` in 1: condition outcome from execute.
- `m_stat`, `W_stat` in 3 each: memory-stage and writeback status.
- `W_valid` in 1: W holds a real instruction, not a bubble.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`, `set_cc` out 1 each: pipeline controls.
- `proc_stat` out 3: registered processor status.
- `halted` out 1: FSM is not in RUN.
- `timeout` out 1: FSM is in TIMEOUT.
- `cycle_cnt`, `retired_cnt`, `lu_stall_cnt`, `mispred_cnt`, `ret_cnt` out `CNT_W` each: performance counters.

## Operation
Encodings:
- Stat: AOK=1, HLT=2, ADR=3, INS=4.
- icode: MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=B.
- RNONE=F.

Hazard terms, computed combinationally:
- `lu` = E_icode∈{MRMOVQ,POPQ} ∧ E_dstM≠RNONE ∧ E_dstM∈{d_srcA,d_srcB}.
- `mp` = E_icode==JXX ∧ !e_cnd.
- `rt` = RET∈{D_icode,E_icode,M_icode}.
- `mx` = m_stat∈{HLT,ADR,INS}.
- `wx` = W_stat∈{HLT,ADR,INS}.

Outputs in RUN:
- F_stall = lu ∨ rt.
- D_stall = lu.
- D_bubble = mp ∨ (!lu ∧ rt).
- E_bubble = mp ∨ lu.
- M_bubble = mx ∨ wx.
- W_stall = wx.
- set_cc = E_icode==OPQ ∧ !mx ∧ !wx.

Outputs in HALTED, TIMEOUT or while `rst`=1:
- F_stall=D_stall=W_stall=1 (0 during `rst`).
- E_bubble=M_bubble=1.
- D_bubble = 1 only during `rst`, otherwise 0.
- set_cc=0.

FSM states: RUN, HALTED, TIMEOUT.
- RUN→HALTED when wx; `proc_stat` latches W_stat on the same edge.
- RUN→TIMEOUT when MAX_CYCLES≠0 ∧ cycle_cnt==MAX_CYCLES−1; `proc_stat` is unchanged.
- If both conditions hold on the same edge, HALTED wins.
- HALTED and TIMEOUT are absorbing; only `rst` leaves them.

Counters (update only in RUN, saturate at all-ones, no wrap):
- `cycle_cnt`: +1 every RUN cycle.
- `retired_cnt`: +1 when W_valid ∧ W_stat==AOK ∧ !W_stall.
- `lu_stall_cnt`: +1 when lu.
- `mispred_cnt`: +1 when mp.
- `ret_cnt`: +1 when rt ∧ !lu, i.e. each ret bubble cycle.
- A single cycle may increment several counters.
- All counters are frozen outside RUN.

## Timing
- Reset values: state RUN, proc_stat=AOK(1), halted=0, timeout=0, all counters 0.
- Control outputs are combinational from inputs and state; zero latency.
- `proc_stat`, `halted`, `timeout` and counters are registered; they change one edge after the triggering condition.
- `rst` asserted mid-operation, including in HALTED, returns all registered state to reset values on that edge.
- The first RUN cycle after reset deassertion counts as cycle_cnt 0→1.

## Test plan
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0; lu_stall_cnt +1 after the edge.
- E_dstM=F with d_srcB=F → no stall; lu=0.
- Mispredict: E_icode=7, e_cnd=0 → D_bubble=E_bubble=1, F_stall=0; mispred_cnt +1. With e_cnd=1 → all controls 0.
- Ret: M_icode=9 with no lu → F_stall=1, D_bubble=1, for each of 3 consecutive cycles; ret_cnt=3. Combined with lu → D_stall=1, D_bubble=0.
- Halt: W_stat=2, W_valid=1 → W_stall=M_bubble=1 and set_cc=0 immediately. Next edge: halted=1, proc_stat=2, counters frozen. Later `rst` → proc_stat=1, counters 0.
- Watchdog: MAX_CYCLES=8, all inputs AOK/NOP → after 8 edges timeout=1, halted=1, cycle_cnt=8, proc_stat=1. Same-edge wx → HALTED, timeout=0.
- Saturation: CNT_W=3, W_valid=1, W_stat=AOK for 10 cycles → retired_cnt sticks at 7.
